// File: rtl/mem_lsu.sv
// Load/store front-end for the byte-addressed data memory: takes one request at a time,
// drives the memory port and returns a registered, sign/zero-extended response.

package mem_lsu_pkg;
    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } tsize_e;
endpackage

// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory port driven with the latched request; load data sampled here
// WCHK   | store issued, collecting the memory's registered write error
// RESP   | response held until the consumer takes it
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int N = 1024,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  tsize_e        req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_error,
    output logic [AW-1:0] mem_address,
    output tsize_e        mem_tsize,
    output logic          mem_write,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_data,
    input  logic          mem_rerror,
    input  logic          mem_werror
);
    typedef enum logic [1:0] {IDLE, ACCESS, WCHK, RESP} state_t;

    state_t      state, state_n;
    logic        lat_write, lat_unsigned;
    logic [31:0] lat_addr, lat_wdata;
    tsize_e      lat_size;

    logic        accept, in_range, size_ok, rsp_load, error_n;
    logic [31:0] rdata_n, load_data;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && req_ready;
    assign in_range       = (lat_addr[31:AW] == '0);
    assign size_ok        = (lat_size == BYTE) || (lat_size == HALFWORD) || (lat_size == WORD);
    assign mem_address    = lat_addr[AW-1:0];
    assign mem_tsize      = lat_size;
    assign mem_write_data = lat_wdata;
    // Gated by rst so a store caught by reset never reaches the memory.
    assign mem_write      = (state == ACCESS) && lat_write && in_range && !rst;

    always_comb begin
        load_data = mem_data;
        if (!lat_unsigned) begin
            case (lat_size)
                BYTE:     load_data = {{24{mem_data[7]}}, mem_data[7:0]};
                HALFWORD: load_data = {{16{mem_data[15]}}, mem_data[15:0]};
                default:  load_data = mem_data;
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        rsp_load = 1'b0;
        rdata_n  = '0;
        error_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = ACCESS;
            end
            ACCESS: begin
                if (!in_range) begin
                    rsp_load = 1'b1;
                    error_n  = 1'b1;
                    state_n  = RESP;
                end else if (lat_write) begin
                    state_n = WCHK;
                end else begin
                    rsp_load = 1'b1;
                    if (mem_rerror || !size_ok) error_n = 1'b1;
                    else                        rdata_n = load_data;
                    state_n = RESP;
                end
            end
            WCHK: begin
                rsp_load = 1'b1;
                error_n  = mem_werror;
                state_n  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_size     <= BYTE;
            lat_unsigned <= 1'b0;
            lat_wdata    <= '0;
        end else begin
            state     <= state_n;
            rsp_valid <= (state_n == RESP);
            if (accept) begin
                lat_write    <= req_write;
                lat_addr     <= req_addr;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_wdata    <= req_wdata;
            end
            if (rsp_load) begin
                rsp_rdata <= rdata_n;
                rsp_error <= error_n;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: little-endian memory stub, byte-array reference model and a
// per-cycle response checker, plus literal expectations for the directed cases.

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int N  = 1024;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic          req_ready, rsp_valid, rsp_error, mem_write, mem_rerror;
    logic          rsp_ready = 1'b1;
    logic [31:0]   req_addr = '0, req_wdata = '0;
    tsize_e        req_size = BYTE;
    logic [31:0]   rsp_rdata, mem_write_data, mem_data;
    logic [AW-1:0] mem_address;
    tsize_e        mem_tsize;
    logic          werror;
    logic          preload = 1'b1;

    always #5 clk = ~clk;

    mem_lsu #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .mem_address(mem_address), .mem_tsize(mem_tsize), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_data(mem_data),
        .mem_rerror(mem_rerror), .mem_werror(werror)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_pulses = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int alg(input logic [1:0] s);
        case (s)
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 1;
        endcase
    endfunction

    // Memory stub: combinational zero-extended read, registered write error.
    logic [7:0] mem [N];
    logic       stub_ok;

    always_comb begin
        mem_data = '0;
        for (int k = 0; k < 4; k++)
            if (k < wid(mem_tsize)) mem_data[8*k +: 8] = mem[(int'(mem_address) + k) % N];
        mem_rerror = (int'(mem_address) % alg(mem_tsize)) != 0;
        stub_ok    = !mem_rerror && (mem_tsize != tsize_e'(2'd3));
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < N; i++) mem[i] <= i[7:0];
            werror <= 1'b0;
        end else begin
            werror <= 1'b0;
            if (mem_write) begin
                wr_pulses <= wr_pulses + 1;
                if (!stub_ok) werror <= 1'b1;
                else
                    for (int k = 0; k < 4; k++)
                        if (k < wid(mem_tsize))
                            mem[(int'(mem_address) + k) % N] <= mem_write_data[8*k +: 8];
            end
        end
    end

    // Reference model: byte array plus plain arithmetic on the request rules.
    logic [7:0] ref_mem [N];

    task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd,
                         output int lat, output int pulses);
        logic [31:0] v;
        logic        good;
        good   = (s != 2'd3) && ((a % alg(s)) == 0);
        err    = 1'b0;
        rd     = '0;
        lat    = 1;
        pulses = 0;
        if (a >= 32'(N)) begin
            err = 1'b1;
        end else if (w) begin
            lat    = 2;
            pulses = 1;
            if (good) for (int k = 0; k < wid(s); k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            else      err = 1'b1;
        end else if (!good) begin
            err = 1'b1;
        end else begin
            v = '0;
            for (int k = 0; k < wid(s); k++) v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
            if (!u && s == 2'd0 && v >= 32'd128)   v = v - 32'd256;
            if (!u && s == 2'd1 && v >= 32'd32768) v = v - 32'd65536;
            rd = v;
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Response checker: on rsp_valid rising compare against the model, then hold stable.
    initial begin
        exp_t cur;
        logic was_valid;
        was_valid = 1'b0;
        cur = '{err: 1'b0, rd: '0, lat: 0, acc: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                was_valid = 1'b0;
            end else begin
                if (rsp_valid && !was_valid) begin
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_rsp");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, cur.rd);
                        chk("rsp_error", 32'(rsp_error), 32'(cur.err));
                        chk("rsp_latency", cyc - cur.acc, cur.lat);
                    end
                end else if (rsp_valid) begin
                    chk("hold_rdata", rsp_rdata, cur.rd);
                    chk("hold_error", 32'(rsp_error), 32'(cur.err));
                end
                if (rsp_valid) chk("ready_in_resp", 32'(req_ready), 32'd0);
                was_valid = rsp_valid;
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd, input int hold,
                       input logic junk,
                       output logic [31:0] got_rd, output logic got_err);
        exp_t e;
        int   pulses, p0, n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("req_ready_wait");
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_size     = tsize_e'(s);
        req_unsigned = u;
        req_wdata    = wd;
        rsp_ready    = (hold == 0);
        p0           = wr_pulses;
        @(posedge clk);
        #1;
        model(w, a, s, u, wd, e.err, e.rd, e.lat, pulses);
        e.acc    = cyc;
        last_acc = cyc;
        exp_q.push_back(e);
        if (junk) begin
            // Keep a conflicting request on the bus while this one is in flight.
            req_write = 1'b1;
            req_addr  = 32'h300;
            req_size  = WORD;
            req_wdata = 32'hBAD0BAD0;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (!rsp_valid) timeout("rsp_valid_wait");
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        got_rd    = rsp_rdata;
        got_err   = rsp_error;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
        chk("mem_write_pulses", wr_pulses - p0, pulses);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          prev, p0;

        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          prev, p0;

        for (int i = 0; i < N; i++) ref_mem[i] = i[7:0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_tsize", 32'(mem_tsize), 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd, er);
        chk("st_word_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_word", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h11, 2'd0, 1'b0, 32'h80, 0, 1'b0, rd, er);
        txn(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_byte_s", rd, 32'hFFFFFF80);
        txn(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 0, 1'b0, rd, er);
        chk("ld_byte_u", rd, 32'h00000080);
        txn(1'b1, 32'h12, 2'd1, 1'b0, 32'h8001, 0, 1'b0, rd, er);
        txn(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_half_s", rd, 32'hFFFF8001);

        txn(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_misal_err", 32'(er), 32'd1);
        chk("ld_misal_rd", rd, 32'd0);
        txn(1'b1, 32'h06, 2'd2, 1'b0, 32'h12345678, 0, 1'b0, rd, er);
        chk("st_misal_err", 32'(er), 32'd1);
        txn(1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("misal_untouched_lo", rd, 32'h07060504);
        txn(1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("misal_untouched_hi", rd, 32'h0B0A0908);

        txn(1'b1, 32'h400, 2'd2, 1'b0, 32'hFFFFFFFF, 0, 1'b0, rd, er);
        chk("st_oor_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_after_oor", rd, 32'h03020100);
        txn(1'b0, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_oor_err", 32'(er), 32'd1);
        txn(1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_top_word", rd, 32'hFFFEFDFC);
        txn(1'b0, 32'h3FE, 2'd1, 1'b1, 32'h0, 0, 1'b0, rd, er);
        chk("ld_top_half_u", rd, 32'h0000FFFE);
        txn(1'b0, 32'h20, 2'd3, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("ld_bad_size_err", 32'(er), 32'd1);

        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, 1'b1, rd, er);
        chk("ld_held", rd, 32'h800180EF);
        txn(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("junk_ignored", rd, 32'h03020100);

        txn(1'b1, 32'h100, 2'd2, 1'b0, 32'h11111111, 0, 1'b0, rd, er);
        txn(1'b1, 32'h100, 2'd1, 1'b0, 32'h00002222, 0, 1'b0, rd, er);
        txn(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("overwrite", rd, 32'h11112222);

        prev = last_acc;
        txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("thru_load", last_acc - prev, 3);
        prev = last_acc;
        txn(1'b1, 32'h44, 2'd2, 1'b0, 32'hA5A5A5A5, 0, 1'b0, rd, er);
        chk("thru_load_store", last_acc - prev, 3);
        prev = last_acc;
        txn(1'b1, 32'h48, 2'd0, 1'b0, 32'h5A, 0, 1'b0, rd, er);
        chk("thru_store", last_acc - prev, 4);

        // Reset lands while a store sits in ACCESS.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h200;
        req_size  = WORD;
        req_wdata = 32'hCAFEF00D;
        p0        = wr_pulses;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_access_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_access_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_access_ready", 32'(req_ready), 32'd1);
        chk("rst_access_pulses", wr_pulses - p0, 0);
        rst = 1'b0;
        txn(1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er);
        chk("rst_store_dropped", rd, 32'h03020100);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) timeout("pending_responses");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
